// File: rtl/piso_stream_if.sv
// rtl/piso_stream_if.sv - word-in / bit-out handshake bundle for piso_stream
interface piso_stream_if #(
  parameter int SIZE = 8
);
  logic [SIZE-1:0] data_in;
  logic            lsb_first_in;
  logic            valid_in;
  logic            ready_out;
  logic            data_out;
  logic            bit_strobe_out;
  logic            busy_out;
  logic            done_out;

  modport master (
    output data_in, lsb_first_in, valid_in,
    input  ready_out, data_out, bit_strobe_out, busy_out, done_out
  );

  modport slave (
    input  data_in, lsb_first_in, valid_in,
    output ready_out, data_out, bit_strobe_out, busy_out, done_out
  );
endinterface

// File: rtl/piso_stream.sv
// rtl/piso_stream.sv - parallel-in serial-out shifter with one-word holding buffer
// Words shift back-to-back with no gap when the buffer is refilled before a word ends.
module piso_stream #(
  parameter int SIZE = 8,
  parameter int DIV  = 4
) (
  input logic         clk_in,
  input logic         rst_n_in,
  piso_stream_if.slave bus
);
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW = $clog2(SIZE);
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(SIZE - 1);
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  logic [0:0]      state_q, state_d;
  logic            buf_full_q, buf_full_d;
  logic [SIZE-1:0] buf_data_q, buf_data_d;
  logic            buf_lsb_q, buf_lsb_d;
  logic [SIZE-1:0] sreg_q, sreg_d;
  logic            lsb_q, lsb_d;
  logic [PW-1:0]   pre_q, pre_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic            done_q, done_d;

  logic accept, end_bit, end_word, load;

  // Accept only looks at the registered full flag, so a draining buffer never accepts.
  assign accept   = bus.valid_in & ~buf_full_q;
  assign end_bit  = (state_q == ST_SHIFT) && (pre_q == PRE_LAST);
  assign end_word = end_bit && (bit_q == BIT_LAST);
  assign load     = buf_full_q && ((state_q == ST_IDLE) || end_word);

  always_comb begin
    state_d    = state_q;
    buf_full_d = buf_full_q;
    buf_data_d = buf_data_q;
    buf_lsb_d  = buf_lsb_q;
    sreg_d     = sreg_q;
    lsb_d      = lsb_q;
    pre_d      = pre_q;
    bit_d      = bit_q;
    done_d     = end_word;

    if (accept) begin
      buf_full_d = 1'b1;
      buf_data_d = bus.data_in;
      buf_lsb_d  = bus.lsb_first_in;
    end else if (load) begin
      buf_full_d = 1'b0;
    end

    if (load) begin
      state_d = ST_SHIFT;
      sreg_d  = buf_data_q;
      lsb_d   = buf_lsb_q;
      pre_d   = '0;
      bit_d   = '0;
    end else if (end_word) begin
      state_d = ST_IDLE;
      sreg_d  = '0;
      pre_d   = '0;
      bit_d   = '0;
    end else if (state_q == ST_SHIFT) begin
      if (end_bit) begin
        pre_d  = '0;
        bit_d  = bit_q + BW'(1);
        sreg_d = lsb_q ? {1'b0, sreg_q[SIZE-1:1]} : {sreg_q[SIZE-2:0], 1'b0};
      end else begin
        pre_d = pre_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= ST_IDLE;
      buf_full_q <= 1'b0;
      buf_data_q <= '0;
      buf_lsb_q  <= 1'b0;
      sreg_q     <= '0;
      lsb_q      <= 1'b0;
      pre_q      <= '0;
      bit_q      <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf_full_q <= buf_full_d;
      buf_data_q <= buf_data_d;
      buf_lsb_q  <= buf_lsb_d;
      sreg_q     <= sreg_d;
      lsb_q      <= lsb_d;
      pre_q      <= pre_d;
      bit_q      <= bit_d;
      done_q     <= done_d;
    end
  end

  assign bus.ready_out      = ~buf_full_q;
  assign bus.busy_out       = (state_q == ST_SHIFT);
  assign bus.bit_strobe_out = (state_q == ST_SHIFT) && (pre_q == '0);
  assign bus.data_out       = (state_q == ST_SHIFT) && (lsb_q ? sreg_q[0] : sreg_q[SIZE-1]);
  assign bus.done_out       = done_q;
endmodule

// File: tb/tb_piso_stream.sv
// tb/tb_piso_stream.sv - scoreboard bench for piso_stream (DIV=2 and DIV=1 instances)
module tb_piso_stream;
  localparam int DA = 2;
  localparam int DB = 1;

  typedef struct packed {
    logic b;  // expected data_out
    logic s;  // expected bit_strobe_out
    logic l;  // last cycle of a word
    logic c;  // must follow the previous cycle with no gap
  } ent_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  ent_t qa[$];
  ent_t qb[$];
  ent_t ea, eb;
  logic exp_done_a, exp_done_b, popped_a, popped_b;

  piso_stream_if #(.SIZE(8)) a_if ();
  piso_stream_if #(.SIZE(8)) b_if ();

  piso_stream #(.SIZE(8), .DIV(DA)) dut_a (.clk_in(clk), .rst_n_in(rst_n), .bus(a_if));
  piso_stream #(.SIZE(8), .DIV(DB)) dut_b (.clk_in(clk), .rst_n_in(rst_n), .bus(b_if));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // pat is the hand-computed serial order, pat[7] transmitted first
  task automatic push_exp(input bit to_b, input logic [7:0] pat, input logic cont);
    ent_t e;
    int   d;
    d = to_b ? DB : DA;
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < d; j++) begin
        e.b = pat[7-i];
        e.s = (j == 0);
        e.l = (i == 7) && (j == d - 1);
        e.c = (i == 0 && j == 0) ? cont : 1'b1;
        if (to_b) qb.push_back(e);
        else      qa.push_back(e);
      end
    end
  endtask

  task automatic send_a(input logic [7:0] w, input logic lsb, input logic [7:0] pat, input logic cont);
    int n;
    push_exp(1'b0, pat, cont);
    @(negedge clk);
    a_if.data_in      = w;
    a_if.lsb_first_in = lsb;
    a_if.valid_in     = 1'b1;
    n = 0;
    while (!a_if.ready_out && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("a_accept_wait", 32'(n < 200), 32'd1);
    @(posedge clk);
  endtask

  task automatic send_b(input logic [7:0] w, input logic lsb, input logic [7:0] pat);
    int n;
    push_exp(1'b1, pat, 1'b0);
    @(negedge clk);
    b_if.data_in      = w;
    b_if.lsb_first_in = lsb;
    b_if.valid_in     = 1'b1;
    n = 0;
    while (!b_if.ready_out && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("b_accept_wait", 32'(n < 200), 32'd1);
    @(posedge clk);
    #1 b_if.valid_in = 1'b0;
  endtask

  task automatic drain(input bit on_b);
    int n;
    n = 0;
    while ((on_b ? (qb.size() != 0 || b_if.busy_out) : (qa.size() != 0 || a_if.busy_out)) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk(on_b ? "b_drain" : "a_drain", 32'(n < 500), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_reset_outs(input string who, input logic d, input logic s, input logic bz, input logic dn, input logic rd);
    chk({who, "_rst_data"},   d,  1'b0);
    chk({who, "_rst_strobe"}, s,  1'b0);
    chk({who, "_rst_busy"},   bz, 1'b0);
    chk({who, "_rst_done"},   dn, 1'b0);
    chk({who, "_rst_ready"},  rd, 1'b1);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      qa.delete();
      exp_done_a = 1'b0;
      popped_a   = 1'b0;
    end else begin
      chk("a_done", a_if.done_out, exp_done_a);
      exp_done_a = 1'b0;
      if (a_if.busy_out) begin
        if (qa.size() == 0) begin
          chk("a_unexpected_busy", a_if.busy_out, 1'b0);
        end else begin
          ea = qa.pop_front();
          chk("a_data", a_if.data_out, ea.b);
          chk("a_strobe", a_if.bit_strobe_out, ea.s);
          exp_done_a = ea.l;
          popped_a   = 1'b1;
        end
      end else begin
        chk("a_idle_data", a_if.data_out, 1'b0);
        chk("a_idle_strobe", a_if.bit_strobe_out, 1'b0);
        if (popped_a && qa.size() != 0 && qa[0].c) chk("a_gap", a_if.busy_out, 1'b1);
        popped_a = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      qb.delete();
      exp_done_b = 1'b0;
      popped_b   = 1'b0;
    end else begin
      chk("b_done", b_if.done_out, exp_done_b);
      exp_done_b = 1'b0;
      if (b_if.busy_out) begin
        if (qb.size() == 0) begin
          chk("b_unexpected_busy", b_if.busy_out, 1'b0);
        end else begin
          eb = qb.pop_front();
          chk("b_data", b_if.data_out, eb.b);
          chk("b_strobe", b_if.bit_strobe_out, eb.s);
          exp_done_b = eb.l;
          popped_b   = 1'b1;
        end
      end else begin
        chk("b_idle_data", b_if.data_out, 1'b0);
        if (popped_b && qb.size() != 0 && qb[0].c) chk("b_gap", b_if.busy_out, 1'b1);
        popped_b = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad   = 0;
    a_if.data_in = '0; a_if.lsb_first_in = 1'b0; a_if.valid_in = 1'b0;
    b_if.data_in = '0; b_if.lsb_first_in = 1'b0; b_if.valid_in = 1'b0;
    rst_n = 1'b0;
    #2;
    chk_reset_outs("a_init", a_if.data_out, a_if.bit_strobe_out, a_if.busy_out, a_if.done_out, a_if.ready_out);
    chk_reset_outs("b_init", b_if.data_out, b_if.bit_strobe_out, b_if.busy_out, b_if.done_out, b_if.ready_out);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    // 0xA5 MSB-first, with first-bit latency check
    send_a(8'hA5, 1'b0, 8'b1010_0101, 1'b0);
    #1 a_if.valid_in = 1'b0;
    @(negedge clk);
    chk("a5_busy_before_load", a_if.busy_out, 1'b0);
    chk("a5_ready_while_full", a_if.ready_out, 1'b0);
    @(negedge clk);
    chk("a5_busy_first_bit", a_if.busy_out, 1'b1);
    chk("a5_first_bit", a_if.data_out, 1'b1);
    drain(1'b0);

    // 0x01 LSB-first then 0x01 MSB-first, back to back
    send_a(8'h01, 1'b1, 8'b1000_0000, 1'b0);
    send_a(8'h01, 1'b0, 8'b0000_0001, 1'b1);
    #1 a_if.valid_in = 1'b0;
    drain(1'b0);

    // 0xF0 then 0x0F with valid held high: 16 contiguous bits
    send_a(8'hF0, 1'b0, 8'b1111_0000, 1'b0);
    send_a(8'h0F, 1'b0, 8'b0000_1111, 1'b1);
    #1 a_if.valid_in = 1'b0;
    @(negedge clk);
    chk("f00f_ready_low_full", a_if.ready_out, 1'b0);
    repeat (6) @(negedge clk);
    chk("f00f_ready_still_low", a_if.ready_out, 1'b0);
    drain(1'b0);

    // reset after 3 bits of 0xFF, then 0x80
    send_a(8'hFF, 1'b0, 8'b1111_1111, 1'b0);
    #1 a_if.valid_in = 1'b0;
    repeat (6) @(posedge clk);
    chk("ff_busy_before_reset", a_if.busy_out, 1'b1);
    #3 rst_n = 1'b0;
    #1;
    chk_reset_outs("a_mid", a_if.data_out, a_if.bit_strobe_out, a_if.busy_out, a_if.done_out, a_if.ready_out);
    @(posedge clk);
    #3 rst_n = 1'b1;
    send_a(8'h80, 1'b0, 8'b1000_0000, 1'b0);
    #1 a_if.valid_in = 1'b0;
    drain(1'b0);

    // DIV=1: 0x81 on 8 consecutive cycles, strobe every cycle
    send_b(8'h81, 1'b0, 8'b1000_0001);
    drain(1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/piso_stream.md
PISO_STREAM -- requirements
Module: piso_stream

Interface
REQ-001 SHALL have parameter SIZE, default 8, word width in bits; legal range >= 2.
REQ-002 SHALL have parameter DIV, default 4, clk_in cycles per serial bit; legal range >= 1.
REQ-003 SHALL have port clk_in, input, 1, single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n_in, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port data_in, input, SIZE, parallel word to serialise.
REQ-006 SHALL have port lsb_first_in, input, 1, bit-order select; sampled with data_in at accept.
REQ-007 SHALL have port valid_in, input, 1, data_in/lsb_first_in valid.
REQ-008 SHALL have port ready_out, output, 1, holding buffer can take a word.
REQ-009 SHALL have port data_out, output, 1, serial bit stream.
REQ-010 SHALL have port bit_strobe_out, output, 1, high in first cycle of every bit period.
REQ-011 SHALL have port busy_out, output, 1, high while a word is being shifted.
REQ-012 SHALL have port done_out, output, 1, one-cycle pulse per completed word.

Function
REQ-013 SHALL accept a word at a rising edge where valid_in=1 and ready_out=1; data_in and lsb_first_in are stored in a one-entry holding buffer.
REQ-014 SHALL drive ready_out = NOT(holding buffer full), registered; no accept while full, even when the buffer drains at the same edge.
REQ-015 SHALL have states IDLE and SHIFT; busy_out=1 exactly in SHIFT.
REQ-016 In IDLE with buffer full, SHALL at the next edge load the shift register from the buffer, empty the buffer, enter SHIFT, clear bit and prescale counters; first bit is on data_out one cycle after the accept edge.
REQ-017 SHALL hold each bit on data_out for exactly DIV cycles; bit_strobe_out=1 when prescale counter = 0 in SHIFT, else 0.
REQ-018 MSB-first (latched lsb_first=0): data_out = shift_reg[SIZE-1], shift left by 1 at bit-period end; LSB-first: data_out = shift_reg[0], shift right by 1.
REQ-019 At the edge ending bit SIZE-1 (prescale = DIV-1, bit count = SIZE-1) with buffer full, SHALL load the next word and stay in SHIFT with zero gap cycles.
REQ-020 At that edge with buffer empty, SHALL enter IDLE; data_out = 0 in IDLE.
REQ-021 SHALL assert done_out for exactly one cycle following every edge that ends bit SIZE-1 of a word.
REQ-022 Counters SHALL be sized clog2 of their range (min 1 bit) and SHALL never exceed SIZE-1 / DIV-1.
REQ-023 With DIV=1, SHALL emit one bit per cycle with bit_strobe_out constantly 1 in SHIFT.
REQ-024 An accept during SHIFT SHALL NOT disturb the word being shifted.

Reset
REQ-025 While rst_n_in=0, SHALL immediately force: data_out=0, bit_strobe_out=0, busy_out=0, done_out=0, ready_out=1, state IDLE, buffer empty, counters and shift register 0.
REQ-026 Reset mid-word SHALL discard the in-flight and held words with no done_out pulse; operation resumes on the first edge after release.

Verification (SIZE=8, DIV=2 unless stated)
REQ-027 Reset: assert rst_n_in mid-run -> outputs at REQ-025 values without waiting for a clock edge.
REQ-028 Accept 0xA5, lsb_first_in=0 -> data_out 1,0,1,0,0,1,0,1, each bit 2 cycles, first bit 1 cycle after accept, 8 strobes, done_out pulse after bit 7, busy_out falls, data_out returns to 0.
REQ-029 Accept 0x01 with lsb_first_in=1, then 0x01 with lsb_first_in=0 -> first word 1,0,0,0,0,0,0,0; second word 0,0,0,0,0,0,0,1.
REQ-030 valid_in held high with 0xF0 then 0x0F -> 16 contiguous bits 1111000000001111, no gap; ready_out low while buffer full; two done_out pulses 16 cycles apart.
REQ-031 Reset asserted after 3 bits of 0xFF -> data_out=0 immediately, no done_out; after release, 0x80 serialises cleanly as 1,0,0,0,0,0,0,0.
REQ-032 DIV=1, accept 0x81 -> data_out 1,0,0,0,0,0,0,1 on 8 consecutive cycles, bit_strobe_out=1 on all 8.
